// File: rtl/bitonic_pkg.sv
// Shared types and sizing helpers for the sequential bitonic sorter.
package bitonic_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Number of network stages for a network of 2**logn inputs.
  function automatic int stage_count(input int logn);
    return logn * (logn + 1) / 2;
  endfunction

  localparam int DEFAULT_N = 8;
  localparam int LOGN      = clog2(DEFAULT_N);
  localparam int STAGES    = stage_count(LOGN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DRAIN
  } state_t;

endpackage

// File: rtl/bitonic_cmp_exch.sv
// One compare-exchange element. lo/hi are the words for the lower and higher
// index of the pair; dir=1 puts the smaller word at the lower index.
module bitonic_cmp_exch #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

  // Strict comparisons so equal words never move.
  always_comb begin
    swap = dir ? (a > b) : (a < b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: serial load, one network stage per clock through
// a shared bank of N/2 compare-exchange elements, then serial drain.
module bitonic_sort_seq
  import bitonic_pkg::*;
#(
  parameter int N      = 8,
  parameter int W      = 8,
  parameter bit ASCEND = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int LOG_N      = clog2(N);
  localparam int NUM_STAGES = stage_count(LOG_N);
  localparam int SW         = clog2(NUM_STAGES + 1);
  localparam int KW         = clog2(LOG_N + 1);
  localparam int HALF       = N / 2;

  state_t            state;
  logic [LOG_N-1:0]  load_cnt;
  logic [LOG_N-1:0]  out_cnt;
  logic [SW-1:0]     stage_cnt;
  logic [KW-1:0]     k_log;
  logic [KW-1:0]     j_log;

  logic [W-1:0]      regs   [N];
  logic [W-1:0]      sorted [N];

  logic [LOG_N-1:0]  idx_lo [HALF];
  logic [LOG_N-1:0]  idx_hi [HALF];
  logic [W-1:0]      cmp_a  [HALF];
  logic [W-1:0]      cmp_b  [HALF];
  logic [W-1:0]      cmp_lo [HALF];
  logic [W-1:0]      cmp_hi [HALF];
  logic              cmp_dir[HALF];

  // Comparator q serves index i = q with a zero inserted at bit j_log;
  // its partner is i with that bit set. Bit k_log of i picks the direction.
  always_comb begin
    int  i_idx;
    logic up;
    // NOTE: every variable gets a value before any conditional use, so no latches are inferred.
    i_idx = 0;
    up    = 1'b0;
    for (int q = 0; q < HALF; q++) begin
      i_idx      = ((q >> j_log) << (j_log + 1'b1)) | (q & ((1 << j_log) - 1));
      up         = ((i_idx >> k_log) & 1) == 0;
      idx_lo[q]  = LOG_N'(i_idx);
      idx_hi[q]  = LOG_N'(i_idx | (1 << j_log));
      cmp_dir[q] = (up == ASCEND);
      cmp_a[q]   = regs[idx_lo[q]];
      cmp_b[q]   = regs[idx_hi[q]];
    end
  end

  for (genvar g = 0; g < HALF; g++) begin : g_cmp
    bitonic_cmp_exch #(
      .W(W)
    ) u_cmp (
      .a  (cmp_a[g]),
      .b  (cmp_b[g]),
      .dir(cmp_dir[g]),
      .lo (cmp_lo[g]),
      .hi (cmp_hi[g])
    );
  end

  always_comb begin
    sorted = regs;
    for (int q = 0; q < HALF; q++) begin
      sorted[idx_lo[q]] = cmp_lo[q];
      sorted[idx_hi[q]] = cmp_hi[q];
    end
  end

  // NOTE: the word array carries no reset; its contents only matter after a full load.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      regs[load_cnt] <= in_data;
    end else if (state == SORT) begin
      regs <= sorted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      out_cnt   <= '0;
      stage_cnt <= '0;
      k_log     <= '0;
      j_log     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
        end

        LOAD: begin
          if (in_valid && in_ready) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LOG_N'(N - 1)) begin
              state     <= SORT;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              stage_cnt <= '0;
              k_log     <= KW'(1);
              j_log     <= '0;
            end
          end
        end

        SORT: begin
          stage_cnt <= stage_cnt + 1'b1;
          // Finishing j=1 opens the next k with j = k/2.
          if (j_log == '0) begin
            k_log <= k_log + 1'b1;
            j_log <= k_log;
          end else begin
            j_log <= j_log - 1'b1;
          end
          if (stage_cnt == SW'(NUM_STAGES - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == LOG_N'(N - 1)) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              out_cnt   <= '0;
              load_cnt  <= '0;
              stage_cnt <= '0;
              k_log     <= '0;
              j_log     <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The word array is frozen during DRAIN, so the output holds across stalls.
  assign out_data = out_valid ? regs[out_cnt] : '0;
  assign out_last = out_valid && (out_cnt == LOG_N'(N - 1));

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Self-checking bench: an ascending and a descending sorter share all inputs
// and are compared against a queue-sort reference of each batch.
module tb_bitonic_sort_seq;

  localparam int N = 8;
  localparam int W = 8;
  localparam int S = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [W-1:0] out_data_a;
  logic         in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [W-1:0] out_data_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;
  logic [W-1:0] cur [N];

  bitonic_sort_seq #(.N(N), .W(W), .ASCEND(1'b1)) dut_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a)
  );

  bitonic_sort_seq #(.N(N), .W(W), .ASCEND(1'b0)) dut_desc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
    .out_last(out_last_d), .busy(busy_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit stall);
    bit done;
    int guard;
    for (int n = 0; n < N; n++) begin
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = cur[n];
        done     = in_valid && in_ready_a;
        step();
        if (done) last_hs = cyc;
        guard++;
        if (!done && guard > 200) begin
          check("load_timeout", 32'(in_ready_a), 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_batch(input bit stall_in, input int stall_idx);
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_d[$];
    int guard;
    for (int n = 0; n < N; n++) exp_a.push_back(cur[n]);
    exp_a.sort();
    exp_d = exp_a;
    exp_d.reverse();

    load(stall_in);
    // Garbage offered while the sorter is not ready must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h5A;

    guard = 0;
    while (!out_valid_a && guard < 50) begin
      check("sort_ready_busy", {in_ready_a, busy_a, in_ready_d, busy_d}, 4'b0101);
      step();
      guard++;
    end
    check("first_valid", {out_valid_a, out_valid_d}, 2'b11);
    check("latency", 32'(cyc - last_hs), 32'(S));

    for (int n = 0; n < N; n++) begin
      guard = 0;
      while (!out_valid_a && guard < 50) begin
        step();
        guard++;
      end
      check("out_valid", {out_valid_a, out_valid_d}, 2'b11);
      check("data_asc", out_data_a, exp_a[n]);
      check("data_desc", out_data_d, exp_d[n]);
      check("out_last", {out_last_a, out_last_d}, {2{n == N - 1}});
      check("drain_ready_busy", {in_ready_a, busy_a}, 2'b01);
      if (n == stall_idx) begin
        out_ready = 1'b0;
        repeat (5) begin
          step();
          check("stall_hold", {out_valid_a, out_data_a, out_data_d, out_last_a},
                {1'b1, exp_a[n], exp_d[n], n == N - 1});
        end
        out_ready = 1'b1;
      end
      if (n == N - 1) in_valid = 1'b0;
      step();
    end
    check("ready_after_last", {in_ready_a, out_valid_a, busy_a, in_ready_d}, 4'b1001);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) step();
    check("reset_ctrl_asc", {in_ready_a, out_valid_a, out_last_a, busy_a}, 4'b0000);
    check("reset_ctrl_desc", {in_ready_d, out_valid_d, out_last_d, busy_d}, 4'b0000);
    check("reset_data", {out_data_a, out_data_d}, 16'h0000);

    rst = 1'b0;
    check("idle_ready", 32'(in_ready_a), 32'd0);
    step();
    check("load_ready", {in_ready_a, in_ready_d}, 2'b11);

    // Reverse-ordered input.
    for (int n = 0; n < N; n++) cur[n] = W'(7 - n);
    run_batch(1'b0, -1);

    // Duplicates, back to back with the previous batch.
    cur = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    run_batch(1'b0, -1);

    // Extreme values; the descending instance covers the largest-first order.
    cur = '{8'd10, 8'd200, 8'd0, 8'd255, 8'd17, 8'd17, 8'd128, 8'd1};
    run_batch(1'b0, -1);

    // Same data with input bubbles and a five-cycle output stall.
    run_batch(1'b1, 3);

    // Abort a batch mid-sort, then sort a fresh one.
    for (int n = 0; n < N; n++) cur[n] = W'($urandom_range(0, 255));
    load(1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_idle", {in_ready_a, out_valid_a, busy_a, out_valid_d}, 4'b0000);
    step();
    check("abort_reload", {in_ready_a, out_valid_a, busy_a}, 3'b100);
    for (int n = 0; n < N; n++) cur[n] = W'(8 - n);
    run_batch(1'b0, -1);

    // Randomized batches; the first draws from a narrow range to force duplicates.
    for (int b = 0; b < 4; b++) begin
      for (int n = 0; n < N; n++)
        cur[n] = (b == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
      run_batch(b[0], (b >= 2) ? int'($urandom_range(0, N - 1)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_seq.md
Name: bitonic_sort_seq

Overview:
Sequential bitonic sorter built around one parallel compare-exchange stage. It loads N words serially, runs the bitonic network one stage per clock, then streams the sorted words out. The block reuses a single stage of N/2 comparators across all log2(N)*(log2(N)+1)/2 network stages, rather than instantiating the full combinational network. It sits between a producer and a consumer that both use valid/ready handshakes.

Parameters:
N, 8, number of words per sort batch; power of two, N >= 2
W, 8, word width in bits; compared unsigned
ASCEND, 1, 1 = output smallest first; 0 = largest first

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts a word this cycle
in_data  in  W  input word
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts a word this cycle
out_data  out  W  output word
out_last  out  1  high with the Nth (final) output word
busy  out  1  high in SORT and DRAIN states

Behaviour:
- Reset values:
  - Outputs: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - Internal: state=IDLE, all counters=0. Register array contents are don't-care.
- State machine:
  - IDLE -> LOAD on the cycle after reset is released; IDLE lasts one cycle.
  - LOAD:
    - in_ready=1.
    - Each in_valid&&in_ready writes in_data to reg[load_cnt] and increments load_cnt.
    - When the Nth word is accepted, go to SORT and clear stage_cnt.
  - SORT:
    - in_ready=0, out_valid=0.
    - Apply one network stage per cycle.
    - After stage S-1 is applied, where S=log2(N)*(log2(N)+1)/2 (S=6 for N=8), go to DRAIN.
  - DRAIN:
    - out_valid=1, out_data=reg[out_cnt], out_last=(out_cnt==N-1).
    - out_cnt increments on each out_valid&&out_ready.
    - After the handshake with out_last=1, go to LOAD with all counters cleared.
- Stage schedule:
  - Stage s maps to pair (k,j), enumerated as k=2,4,..,N with inner loop j=k/2,..,1.
  - For each index i whose partner p=i^j satisfies p>i, the pair's direction is up when (i&k)==0.
  - Up with ASCEND=1: if reg[i]>reg[p], swap. Otherwise the direction inverts.
  - ASCEND=0 inverts every direction.
  - Equal words are never swapped.
- (k,j) is generated from stage_cnt by a small counter pair (k_log, j_log); no ROM is used.
- Latency: exactly S cycles from acceptance of the Nth input to the first out_valid. Minimum batch period is N + S + N cycles.
- Handshakes:
  - in_valid is ignored whenever in_ready=0.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - Input stalls (in_valid=0) and output stalls (out_ready=0) of any length add cycles but change no data.
- rst asserted in any state, including mid-SORT or mid-DRAIN, returns to IDLE the next cycle. The partial batch is discarded; no out_valid is produced for it.
- No overlap: the next batch cannot load until the current DRAIN completes.

Decomposition:
- Package bitonic_pkg holds:
  - function clog2;
  - constant LOGN;
  - constant STAGES = LOGN*(LOGN+1)/2;
  - enum state_t {IDLE, LOAD, SORT, DRAIN}.
- Sub-module bitonic_cmp_exch: combinational compare-exchange.
  - Inputs: a, b (W bits), dir (1 bit).
  - Outputs: lo, hi.
  - Instantiated N/2 times per stage.
  - Operand and destination indices are muxed by the current j and k.

Test Plan:
- Load 7,6,5,4,3,2,1,0 with N=8, W=8, ASCEND=1 and out_ready=1 -> outputs 0..7 in order. out_last is high only on 7. The first out_valid comes 6 cycles after the last input handshake.
- Load 3,3,1,1,2,2,0,0 -> outputs 0,0,1,1,2,2,3,3, confirming duplicates are preserved.
- Set ASCEND=0 and load 10,200,0,255,17,17,128,1 -> outputs 255,200,128,17,17,10,1,0.
- Toggle in_valid randomly during LOAD and hold out_ready=0 for 5 cycles mid-DRAIN -> results are identical to the unstalled run, and out_data is stable during the stall.
- Assert rst for 1 cycle at SORT stage 3, then load 1..8 reversed -> no output from the aborted batch, and the new batch outputs 1..8.
- Run two back-to-back batches -> in_ready=0 throughout SORT and DRAIN, and in_ready rises the cycle after the out_last handshake.
